row_result_drain: RTL and testbench

- Receiver-side counterpart of a systolic PE row: captures the row's packed S-element accumulator bus when the controller signals compute-done.
- Streams the captured elements out one per cycle over a valid/ready interface, toward the result writeback / output FIFO.
- A two-bank ping-pong buffer lets the row be re-armed (sn) and restarted while the previous result is still draining.

---
 rtl/row_result_drain_pkg.sv | 23 ++
 rtl/row_result_drain_if.sv | 19 +
 rtl/row_result_drain_bank_store.sv | 33 +++
 rtl/row_result_drain.sv | 102 ++++++++++
 tb/tb_row_result_drain.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_result_drain_pkg.sv
// Shared systolic-row constants, drain FSM state type and slice helpers.
package row_result_drain_pkg;

  // Default row geometry shared with the PE row
  localparam int PKG_M = 18;
  localparam int PKG_S = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Element index width, never narrower than one bit (covers S=1)
  function automatic int idx_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  // Low bit offset of column k in a packed row; column 0 is the MSB slice
  function automatic int slice_lo(input int k, input int s, input int m);
    return (s - k - 1) * m;
  endfunction

endpackage

// File: rtl/row_result_drain_if.sv
// Valid/ready element stream leaving the drain toward result writeback.
interface row_result_drain_if
  import row_result_drain_pkg::*;
#(
  parameter int M = PKG_M,
  parameter int S = PKG_S
);
  localparam int IW = idx_width(S);

  logic [M-1:0]  data;
  logic          valid;
  logic          ready;
  logic [IW-1:0] idx;
  logic          last;

  modport master (output data, valid, idx, last, input ready);
  modport slave  (input data, valid, idx, last, output ready);

endinterface

// File: rtl/row_result_drain_bank_store.sv
// Two-bank ping-pong storage for captured rows, with element read mux.
module drain_bank_store
  import row_result_drain_pkg::*;
#(
  parameter int M  = PKG_M,
  parameter int S  = PKG_S,
  parameter int IW = idx_width(PKG_S)
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [S*M-1:0] wdata,
  input  logic          rd_bank,
  input  logic [IW-1:0] idx,
  output logic [M-1:0]  rdata
);

  logic [S*M-1:0] bank0;
  logic [S*M-1:0] bank1;
  logic [S*M-1:0] sel_row;

  // Capture the whole row into whichever bank is write-enabled
  always_ff @(posedge clk) begin
    if (we[0]) bank0 <= wdata;
    if (we[1]) bank1 <= wdata;
  end

  // Pick the bank being drained, then the column slice at idx
  always_comb begin
    sel_row = rd_bank ? bank1 : bank0;
    rdata   = sel_row[slice_lo(int'(idx), S, M) +: M];
  end

endmodule

// File: rtl/row_result_drain.sv
// Captures a PE row's accumulator bus on cap and streams it out one
// element per cycle; ping-pong banks let the next row land mid-drain.
module row_result_drain
  import row_result_drain_pkg::*;
#(
  parameter int M = PKG_M,
  parameter int S = PKG_S
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap,
  input  logic [S*M-1:0]  row_data,
  row_result_drain_if.master out,
  output logic            busy,
  output logic            full,
  output logic            overrun,
  input  logic            clr_ovr
);

  localparam int IW = idx_width(S);

  drain_state_t  state;
  logic [IW-1:0] idx;
  logic          rd_bank;
  logic          wr_bank;
  logic [1:0]    bank_full;
  logic [1:0]    we;
  logic [M-1:0]  rd_elem;
  logic          accept;
  logic          last_el;
  logic          final_accept;
  logic          cap_ok;
  logic          cap_drop;

  assign accept       = out.valid && out.ready;
  assign last_el      = (idx == IW'(S - 1));
  assign final_accept = accept && last_el;
  // A final accept frees a bank on this same edge, so a cap is still taken
  assign cap_ok       = cap && (!(&bank_full) || final_accept);
  assign cap_drop     = cap && !cap_ok;
  assign we           = cap_ok ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

  drain_bank_store #(
    .M  (M),
    .S  (S),
    .IW (IW)
  ) u_store (
    .clk     (clk),
    .we      (we),
    .wdata   (row_data),
    .rd_bank (rd_bank),
    .idx     (idx),
    .rdata   (rd_elem)
  );

  // Drain FSM with bank pointers, fill flags and sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      rd_bank   <= 1'b0;
      wr_bank   <= 1'b0;
      bank_full <= 2'b00;
      overrun   <= 1'b0;
    end else begin
      if (final_accept) bank_full[rd_bank] <= 1'b0;
      if (cap_ok) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end

      if (cap_drop)     overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (cap_ok || bank_full[rd_bank]) state <= DRAIN;
        end
        DRAIN: begin
          if (accept) begin
            if (last_el) begin
              idx     <= '0;
              rd_bank <= ~rd_bank;
              if (!(bank_full[~rd_bank] || cap_ok)) state <= IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out.valid = (state == DRAIN);
  assign out.data  = out.valid ? rd_elem : '0;
  assign out.idx   = idx;
  assign out.last  = out.valid && last_el;
  assign busy      = |bank_full;
  assign full      = &bank_full;

endmodule

// File: tb/tb_row_result_drain.sv
// Directed bench for row_result_drain at S=4, M=18.
module tb_row_result_drain;

  localparam int M = 18;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cap;
  logic [S*M-1:0] row_data;
  logic           busy;
  logic           full;
  logic           overrun;
  logic           clr_ovr;

  int vectors    = 0;
  int miscompares = 0;

  row_result_drain_if #(.M(M), .S(S)) out_if ();

  row_result_drain #(.M(M), .S(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .row_data (row_data),
    .out      (out_if),
    .busy     (busy),
    .full     (full),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  always #5 clk = ~clk;

  // Column 0 lands in the MSB slice
  function automatic logic [S*M-1:0] pack4(input int a, input int b, input int c, input int d);
    return {18'(a), 18'(b), 18'(c), 18'(d)};
  endfunction

  // Rows whose columns are base, base+1, base+2, base+3
  function automatic logic [S*M-1:0] seq_row(input int base);
    return pack4(base, base + 1, base + 2, base + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; cap = 1'b0; clr_ovr = 1'b0; out_if.ready = 1'b0; row_data = '0;
    tick(); tick();
    vectors++;
    if (out_if.valid !== 1'b0 || out_if.data !== 18'd0 || out_if.idx !== 2'd0 ||
        out_if.last !== 1'b0 || busy !== 1'b0 || full !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got v=%b d=%0d i=%0d l=%b b=%b f=%b o=%b want all 0",
               out_if.valid, out_if.data, out_if.idx, out_if.last, busy, full, overrun);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    out_if.ready = 1'b1;
    cap = 1'b1; row_data = seq_row(5);
    tick();
    cap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'(5 + k) || out_if.idx !== 2'(k) ||
          out_if.last !== (k == 3)) begin
        miscompares++;
        $display("[TB] FAIL single k=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d l=%b",
                 k, out_if.valid, out_if.data, out_if.idx, out_if.last, 5 + k, k, (k == 3));
      end
      tick();
    end
    vectors++;
    if (out_if.valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_end got v=%b busy=%b want 0 0", out_if.valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int exp = 0;
    out_if.ready = 1'b0;
    cap = 1'b1; row_data = seq_row(5);
    tick();
    cap = 1'b0;
    for (int c = 0; c < 20 && exp < 4; c++) begin
      out_if.ready = pat[c % 4];
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'(5 + exp) || out_if.idx !== 2'(exp) ||
          out_if.last !== (exp == 3)) begin
        miscompares++;
        $display("[TB] FAIL backpressure c=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d",
                 c, out_if.valid, out_if.data, out_if.idx, out_if.last, 5 + exp, exp);
      end
      if (out_if.ready) exp++;
      tick();
    end
    out_if.ready = 1'b1;
    vectors++;
    if (exp != 4 || out_if.valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_end got accepted=%0d v=%b want 4 0", exp, out_if.valid);
    end
  endtask

  task automatic test_pingpong();
    out_if.ready = 1'b1;
    cap = 1'b1; row_data = seq_row(1);
    tick();
    for (int c = 0; c < 8; c++) begin
      cap = (c == 1);
      row_data = seq_row(11);
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'((c < 4) ? 1 + c : 11 + c - 4) ||
          out_if.idx !== 2'(c % 4) || out_if.last !== (c % 4 == 3)) begin
        miscompares++;
        $display("[TB] FAIL pingpong c=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d",
                 c, out_if.valid, out_if.data, out_if.idx, out_if.last,
                 (c < 4) ? 1 + c : 11 + c - 4, c % 4);
      end
      tick();
    end
    cap = 1'b0;
    vectors++;
    if (out_if.valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pingpong_end got v=%b busy=%b want 0 0", out_if.valid, busy);
    end
  endtask

  task automatic test_overrun();
    out_if.ready = 1'b0;
    cap = 1'b1; row_data = seq_row(21); tick();
    row_data = seq_row(31); tick();
    vectors++;
    if (full !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overrun_two got full=%b ovr=%b want 1 0", full, overrun);
    end
    row_data = seq_row(41); tick();
    cap = 1'b0;
    vectors++;
    if (full !== 1'b1 || overrun !== 1'b1 || out_if.data !== 18'd21) begin
      miscompares++;
      $display("[TB] FAIL overrun_third got full=%b ovr=%b d=%0d want 1 1 21", full, overrun, out_if.data);
    end
    out_if.ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'((c < 4) ? 21 + c : 31 + c - 4)) begin
        miscompares++;
        $display("[TB] FAIL overrun_drain c=%0d got v=%b d=%0d want v=1 d=%0d",
                 c, out_if.valid, out_if.data, (c < 4) ? 21 + c : 31 + c - 4);
      end
      tick();
    end
    vectors++;
    if (out_if.valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overrun_after got v=%b busy=%b ovr=%b want 0 0 1", out_if.valid, busy, overrun);
    end
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL overrun_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_simultaneous();
    out_if.ready = 1'b0;
    cap = 1'b1; row_data = seq_row(51); tick();
    row_data = seq_row(61); tick();
    cap = 1'b0;
    out_if.ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cap = (c == 3);
      row_data = seq_row(71);
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'(51 + 10 * (c / 4) + c % 4) ||
          out_if.idx !== 2'(c % 4)) begin
        miscompares++;
        $display("[TB] FAIL simul c=%0d got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                 c, out_if.valid, out_if.data, out_if.idx, 51 + 10 * (c / 4) + c % 4, c % 4);
      end
      tick();
      if (c == 3) begin
        vectors++;
        if (overrun !== 1'b0 || full !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL simul_flags got ovr=%b full=%b want 0 1", overrun, full);
        end
      end
    end
    cap = 1'b0;
    vectors++;
    if (out_if.valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL simul_end got v=%b busy=%b want 0 0", out_if.valid, busy);
    end
  endtask

  task automatic test_set_wins();
    out_if.ready = 1'b0;
    cap = 1'b1; row_data = seq_row(101); tick();
    row_data = seq_row(111); tick();
    clr_ovr = 1'b1; tick();
    cap = 1'b0; clr_ovr = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL set_wins got ovr=%b want 1", overrun);
    end
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    out_if.ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    vectors++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL set_wins_clear got ovr=%b busy=%b want 0 0", overrun, busy);
    end
  endtask

  task automatic test_async_reset();
    out_if.ready = 1'b1;
    cap = 1'b1; row_data = seq_row(81); tick();
    cap = 1'b0;
    tick(); tick();
    out_if.ready = 1'b0;
    vectors++;
    if (out_if.data !== 18'd83 || out_if.idx !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL arst_pending got d=%0d i=%0d want 83 2", out_if.data, out_if.idx);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (out_if.valid !== 1'b0 || out_if.data !== 18'd0 || out_if.idx !== 2'd0 ||
        out_if.last !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL arst_immediate got v=%b d=%0d i=%0d l=%b b=%b f=%b want all 0",
               out_if.valid, out_if.data, out_if.idx, out_if.last, busy, full);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    out_if.ready = 1'b1;
    cap = 1'b1; row_data = seq_row(91); tick();
    cap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_if.valid !== 1'b1 || out_if.data !== 18'(91 + k) || out_if.idx !== 2'(k) ||
          out_if.last !== (k == 3)) begin
        miscompares++;
        $display("[TB] FAIL arst_resume k=%0d got v=%b d=%0d i=%0d l=%b want v=1 d=%0d i=%0d",
                 k, out_if.valid, out_if.data, out_if.idx, out_if.last, 91 + k, k);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_pingpong();
    test_overrun();
    test_simultaneous();
    test_set_wins();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
